// File: rtl/sid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sid_pkg
//  Description : Shared constants, entry layout and parser states for the
//                SID command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sid_pkg;

    // Register address that turns an entry into a delay command
    localparam logic [4:0] DELAY_REG     = 5'h1F;
    // Channel select that writes every SID at once
    localparam logic [2:0] BROADCAST_SEL = 3'd7;

    // Queued entry layout: {sel, reg, data}
    localparam int DATA_W   = 8;
    localparam int DATA_LSB = 0;
    localparam int REG_W    = 5;
    localparam int REG_LSB  = 8;
    localparam int SEL_W    = 3;
    localparam int SEL_LSB  = 13;
    localparam int ENTRY_W  = 16;

    typedef enum logic [0:0] {
        WAIT_ADDR = 1'b0,
        WAIT_DATA = 1'b1
    } parser_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO. Pointers carry one extra wrap bit so full
//                and empty are unambiguous; dout shows the head entry whenever
//                the FIFO is not empty. Pushes while full are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/sid_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sid_cmd_sequencer
//  Description : Turns UART byte pairs into timed SID register writes. A tick
//                divider paces the bus, a two-state parser builds entries, a
//                FIFO buffers them and one entry is issued per tick, with
//                delay commands and reset sequencing for SIDs and DACs.
//  Revision    : 1.0 - initial release
// ============================================================================
module sid_cmd_sequencer
    import sid_pkg::*;
#(
    parameter int NUM_SIDS         = 2,
    parameter int CLK_DIV          = 12,
    parameter int FIFO_DEPTH       = 16,
    parameter int DAC_RESET_TICKS  = 3,
    parameter int RX_TIMEOUT_TICKS = 255
) (
    input  logic                CLK_IN,
    input  logic                RSTn_i,
    input  logic [7:0]          rx_data,
    input  logic                rx_received,
    output logic                sid_ce_1m,
    output logic                sid_reset,
    output logic                dac_reset,
    output logic [NUM_SIDS-1:0] sid_we,
    output logic [4:0]          sid_addr,
    output logic [7:0]          sid_data,
    output logic                fifo_overflow,
    output logic                busy
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int DAC_W = (DAC_RESET_TICKS > 1) ? $clog2(DAC_RESET_TICKS) : 1;
    localparam int TO_W  = (RX_TIMEOUT_TICKS > 1) ? $clog2(RX_TIMEOUT_TICKS) : 1;

    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [DAC_W-1:0] DAC_LAST = DAC_W'(DAC_RESET_TICKS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(RX_TIMEOUT_TICKS - 1);

    // ------------------------------------------------------------------
    // Tick divider and reset sequencing
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic             sid_reset_q, sid_reset_d;
    logic             dac_reset_q, dac_reset_d;
    logic [DAC_W-1:0] dac_cnt_q, dac_cnt_d;
    logic             tick;

    assign tick = (div_q == '0);

    // Divider reload and SID/DAC reset release, all advanced on ticks
    always_comb begin
        div_d       = tick ? DIV_LOAD : div_q - DIV_W'(1);
        sid_reset_d = sid_reset_q;
        dac_reset_d = dac_reset_q;
        dac_cnt_d   = dac_cnt_q;
        if (tick) begin
            if (sid_reset_q) begin
                sid_reset_d = 1'b0;
                if (DAC_RESET_TICKS == 0) dac_reset_d = 1'b0;
            end else if (dac_reset_q) begin
                if (dac_cnt_q == DAC_LAST) dac_reset_d = 1'b0;
                else                       dac_cnt_d   = dac_cnt_q + DAC_W'(1);
            end
        end
    end

    // Divider and reset-sequencing registers
    always_ff @(posedge CLK_IN or negedge RSTn_i) begin
        if (!RSTn_i) begin
            div_q       <= DIV_LOAD;
            sid_reset_q <= 1'b1;
            dac_reset_q <= 1'b1;
            dac_cnt_q   <= '0;
        end else begin
            div_q       <= div_d;
            sid_reset_q <= sid_reset_d;
            dac_reset_q <= dac_reset_d;
            dac_cnt_q   <= dac_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Byte-pair parser
    // ------------------------------------------------------------------
    parser_state_e      state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [REG_W-1:0]   reg_q, reg_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               fifo_push;
    logic [ENTRY_W-1:0] fifo_din;
    logic               fifo_full;
    logic               ovf_q, ovf_d;

    // Address byte latches sel/reg, data byte pushes; stale address times out
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        reg_d     = reg_q;
        to_cnt_d  = to_cnt_q;
        fifo_push = 1'b0;
        fifo_din  = {sel_q, reg_q, rx_data};
        if (!sid_reset_q) begin
            case (state_q)
                WAIT_ADDR: begin
                    if (rx_received) begin
                        sel_d    = rx_data[7:5];
                        reg_d    = rx_data[4:0];
                        to_cnt_d = '0;
                        state_d  = WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (rx_received) begin
                        fifo_push = 1'b1;
                        state_d   = WAIT_ADDR;
                    end else if (tick) begin
                        if (to_cnt_q == TO_LAST) begin
                            sel_d   = '0;
                            reg_d   = '0;
                            state_d = WAIT_ADDR;
                        end else begin
                            to_cnt_d = to_cnt_q + TO_W'(1);
                        end
                    end
                end
                default: state_d = WAIT_ADDR;
            endcase
        end
        ovf_d = ovf_q | (fifo_push & fifo_full);
    end

    // Parser registers and sticky overflow flag
    always_ff @(posedge CLK_IN or negedge RSTn_i) begin
        if (!RSTn_i) begin
            state_q  <= WAIT_ADDR;
            sel_q    <= '0;
            reg_q    <= '0;
            to_cnt_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            reg_q    <= reg_d;
            to_cnt_q <= to_cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_empty;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK_IN),
        .rst_n (RSTn_i),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Issue stage: one entry per tick, delays and write windows
    // ------------------------------------------------------------------
    logic [SEL_W-1:0]    pop_sel;
    logic [REG_W-1:0]    pop_reg;
    logic [DATA_W-1:0]   pop_data;
    logic [7:0]          delay_q, delay_d;
    logic [NUM_SIDS-1:0] we_q, we_d;
    logic [4:0]          addr_q, addr_d;
    logic [7:0]          data_q, data_d;

    assign pop_sel  = fifo_dout[SEL_LSB  +: SEL_W];
    assign pop_reg  = fifo_dout[REG_LSB  +: REG_W];
    assign pop_data = fifo_dout[DATA_LSB +: DATA_W];

    // A write window lasts until the next tick; each tick either counts the
    // delay down or pops one entry and decodes it
    always_comb begin
        fifo_pop = 1'b0;
        delay_d  = delay_q;
        we_d     = tick ? '0 : we_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (tick && !sid_reset_q) begin
            if (delay_q != 8'd0) begin
                delay_d = delay_q - 8'd1;
            end else if (!fifo_empty) begin
                fifo_pop = 1'b1;
                if (pop_reg == DELAY_REG) begin
                    delay_d = pop_data;
                end else if (pop_sel == BROADCAST_SEL) begin
                    we_d   = '1;
                    addr_d = pop_reg;
                    data_d = pop_data;
                end else if (int'(pop_sel) < NUM_SIDS) begin
                    for (int i = 0; i < NUM_SIDS; i++) begin
                        if (pop_sel == 3'(i)) we_d[i] = 1'b1;
                    end
                    addr_d = pop_reg;
                    data_d = pop_data;
                end
            end
        end
    end

    // Issue-stage registers
    always_ff @(posedge CLK_IN or negedge RSTn_i) begin
        if (!RSTn_i) begin
            delay_q <= 8'd0;
            we_q    <= '0;
            addr_q  <= 5'd0;
            data_q  <= 8'd0;
        end else begin
            delay_q <= delay_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign sid_ce_1m     = tick;
    assign sid_reset     = sid_reset_q;
    assign dac_reset     = dac_reset_q;
    assign sid_we        = we_q;
    assign sid_addr      = addr_q;
    assign sid_data      = data_q;
    assign fifo_overflow = ovf_q;
    assign busy          = !fifo_empty || (delay_q != 8'd0);

endmodule
`default_nettype wire

// File: tb/tb_sid_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sid_cmd_sequencer
//  Description : Directed self-checking bench for sid_cmd_sequencer with a
//                table of single-command vectors plus hand-written sequences
//                for reset release, delays, overflow, timeout and async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sid_cmd_sequencer;

    logic       clk;
    logic       RSTn_i;
    logic [7:0] rx_data;
    logic       rx_received;
    logic       sid_ce_1m;
    logic       sid_reset;
    logic       dac_reset;
    logic [1:0] sid_we;
    logic [4:0] sid_addr;
    logic [7:0] sid_data;
    logic       fifo_overflow;
    logic       busy;

    int total = 0;
    int bad   = 0;

    sid_cmd_sequencer #(
        .NUM_SIDS         (2),
        .CLK_DIV          (12),
        .FIFO_DEPTH       (16),
        .DAC_RESET_TICKS  (3),
        .RX_TIMEOUT_TICKS (255)
    ) dut (
        .CLK_IN        (clk),
        .RSTn_i        (RSTn_i),
        .rx_data       (rx_data),
        .rx_received   (rx_received),
        .sid_ce_1m     (sid_ce_1m),
        .sid_reset     (sid_reset),
        .dac_reset     (dac_reset),
        .sid_we        (sid_we),
        .sid_addr      (sid_addr),
        .sid_data      (sid_data),
        .fifo_overflow (fifo_overflow),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [1:0] we;
        logic [4:0] a;
        logic [7:0] d;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data     = b;
        rx_received = 1'b1;
        step();
        rx_received = 1'b0;
    endtask

    // Observe the first write window within the budget and measure its length
    task automatic watch_write(input int budget, output logic seen, output logic [1:0] we,
                               output logic [4:0] a, output logic [7:0] d,
                               output logic start_ok, output int len);
        logic prev;
        seen = 1'b0; we = '0; a = '0; d = '0; start_ok = 1'b0; len = 0;
        for (int c = 0; c < budget; c++) begin
            prev = sid_ce_1m;
            step();
            if (sid_we != 2'b00) begin
                if (!seen) begin
                    seen = 1'b1; we = sid_we; a = sid_addr; d = sid_data; start_ok = prev;
                end
                if (sid_we == we && sid_addr == a && sid_data == d) len++;
            end
        end
    endtask

    // From reset release: first tick after 11 edges, sid_reset drops after it,
    // dac_reset drops after the third tick that follows
    task automatic check_release(input string tag, input int k0);
        int k;
        int t;
        logic early;
        k = k0;
        while (!sid_ce_1m && k < 100) begin step(); k++; end
        chk({tag, " first_tick_cycles"}, k, 11);
        chk({tag, " sid_reset_held"}, 32'(sid_reset), 1);
        step();
        chk({tag, " sid_reset_released"}, 32'(sid_reset), 0);
        chk({tag, " dac_reset_held"}, 32'(dac_reset), 1);
        t = 0; k = 0; early = 1'b0;
        while (k < 200) begin
            if (dac_reset == 1'b0) early = 1'b1;
            if (sid_ce_1m) begin
                t++;
                if (t == 3) break;
            end
            step(); k++;
        end
        chk({tag, " dac_not_early"}, 32'(early), 0);
        chk({tag, " dac_tick_count"}, t, 3);
        step();
        chk({tag, " dac_reset_released"}, 32'(dac_reset), 0);
    endtask

    // Step until just past a tick edge so following bytes avoid a tick
    task automatic align_after_tick();
        int k;
        k = 0;
        while (!sid_ce_1m && k < 20) begin step(); k++; end
        step();
    endtask

    initial begin : main
        logic       seen;
        logic [1:0] we;
        logic [4:0] a;
        logic [7:0] d;
        logic       sok;
        logic       prev;
        int         len;
        int         k;
        int         t;

        vecs[0] = '{8'h04, 8'hAA, 2'b01, 5'h04, 8'hAA};
        vecs[1] = '{8'hE0, 8'h11, 2'b11, 5'h00, 8'h11};
        vecs[2] = '{8'h40, 8'h11, 2'b00, 5'h00, 8'h00};
        vecs[3] = '{8'h25, 8'h5A, 2'b10, 5'h05, 8'h5A};
        vecs[4] = '{8'hC3, 8'h77, 2'b00, 5'h00, 8'h00};
        vecs[5] = '{8'h1E, 8'hFF, 2'b01, 5'h1E, 8'hFF};

        RSTn_i = 1'b0; rx_received = 1'b0; rx_data = 8'h00;
        repeat (3) step();
        chk("rst sid_reset", 32'(sid_reset), 1);
        chk("rst dac_reset", 32'(dac_reset), 1);
        chk("rst sid_we", 32'(sid_we), 0);
        chk("rst sid_addr", 32'(sid_addr), 0);
        chk("rst sid_data", 32'(sid_data), 0);
        chk("rst overflow", 32'(fifo_overflow), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst ce", 32'(sid_ce_1m), 0);

        // Bytes arriving while sid_reset is high must be ignored
        RSTn_i = 1'b1;
        send_byte(8'h04);
        send_byte(8'hAA);
        check_release("pwr", 2);
        chk("pwr bytes_ignored_busy", 32'(busy), 0);

        // Table of single commands
        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[i].b0);
            send_byte(vecs[i].b1);
            watch_write(50, seen, we, a, d, sok, len);
            if (vecs[i].we == 2'b00) begin
                chk($sformatf("vec%0d no_write", i), 32'(seen), 0);
            end else begin
                chk($sformatf("vec%0d seen", i), 32'(seen), 1);
                chk($sformatf("vec%0d we", i), 32'(we), 32'(vecs[i].we));
                chk($sformatf("vec%0d addr", i), 32'(a), 32'(vecs[i].a));
                chk($sformatf("vec%0d data", i), 32'(d), 32'(vecs[i].d));
                chk($sformatf("vec%0d starts_after_tick", i), 32'(sok), 1);
                chk($sformatf("vec%0d window_len", i), len, 12);
            end
            chk($sformatf("vec%0d idle_after", i), 32'(busy), 0);
        end

        // Delay of 5 ticks then a write: write pops on the 7th tick observed
        align_after_tick();
        send_byte(8'h1F); send_byte(8'h05);
        send_byte(8'h00); send_byte(8'h01);
        t = 0; seen = 1'b0; k = 0;
        while (!seen && k < 150) begin
            prev = sid_ce_1m;
            step(); k++;
            if (prev) t++;
            if (sid_we != 2'b00) begin
                seen = 1'b1; we = sid_we; a = sid_addr; d = sid_data;
            end
        end
        chk("delay seen", 32'(seen), 1);
        chk("delay tick_index", t, 7);
        chk("delay we", 32'(we), 32'h1);
        chk("delay addr", 32'(a), 32'h00);
        chk("delay data", 32'(d), 32'h01);
        chk("delay idle_at_write", 32'(busy), 0);
        repeat (15) step();

        // Overflow: a long delay holds the queue while 17 commands arrive
        align_after_tick();
        send_byte(8'h1F); send_byte(8'h28);
        k = 0;
        while (!sid_ce_1m && k < 20) begin step(); k++; end
        step();
        for (int j = 0; j < 17; j++) begin
            send_byte({3'b000, 5'(j)});
            send_byte(8'h30 + 8'(j));
            if (j == 15) chk("ovf clear_at_16", 32'(fifo_overflow), 0);
        end
        chk("ovf set_at_17", 32'(fifo_overflow), 1);
        k = 0;
        while (sid_we == 2'b00 && k < 700) begin step(); k++; end
        chk("ovf drain_started", 32'(k < 700), 1);
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("ovf drain%0d", j), {19'd0, sid_we, sid_addr, sid_data},
                {19'd0, 2'b01, 5'(j), 8'h30 + 8'(j)});
            repeat (12) step();
        end
        chk("ovf dropped_not_written", 32'(sid_we), 0);
        chk("ovf drained_idle", 32'(busy), 0);
        chk("ovf sticky", 32'(fifo_overflow), 1);

        // Lone address byte abandoned after 255 ticks
        send_byte(8'h03);
        t = 0; k = 0;
        while (t < 255 && k < 5000) begin
            if (sid_ce_1m) t++;
            step(); k++;
        end
        send_byte(8'h05); send_byte(8'h22);
        watch_write(50, seen, we, a, d, sok, len);
        chk("timeout255 addr", 32'(a), 32'h05);
        chk("timeout255 data", 32'(d), 32'h22);
        chk("timeout255 we", 32'(we), 32'h1);

        // One tick short of the timeout the address is still held
        send_byte(8'h03);
        t = 0; k = 0;
        while (t < 254 && k < 5000) begin
            if (sid_ce_1m) t++;
            step(); k++;
        end
        send_byte(8'h05);
        watch_write(50, seen, we, a, d, sok, len);
        chk("timeout254 addr", 32'(a), 32'h03);
        chk("timeout254 data", 32'(d), 32'h05);

        // Asynchronous reset in the middle of a write window
        send_byte(8'h04); send_byte(8'hAA);
        k = 0;
        while (sid_we == 2'b00 && k < 50) begin step(); k++; end
        chk("midrst write_seen", 32'(sid_we), 32'h1);
        repeat (3) step();
        RSTn_i = 1'b0;
        #1;
        chk("midrst sid_we", 32'(sid_we), 0);
        chk("midrst sid_reset", 32'(sid_reset), 1);
        chk("midrst dac_reset", 32'(dac_reset), 1);
        chk("midrst addr", 32'(sid_addr), 0);
        chk("midrst overflow", 32'(fifo_overflow), 0);
        repeat (2) step();
        RSTn_i = 1'b1;
        check_release("midrst", 0);
        chk("midrst idle", 32'(busy), 0);
        chk("midrst no_write", 32'(sid_we), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
